// File: rtl/lsu_pkg.sv
// Shared types and RV32I load/store funct3 encodings for the load/store writeback unit.
package lsu_pkg;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
endpackage

// File: rtl/lsu_wb_if.sv
// Execute-stage, memory and register-file signals of the LSU; slave is the LSU side.
interface lsu_wb_if;
    import lsu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_rd;
    logic              in_rf_wen;
    logic [DATA_W-1:0] in_alu_res;
    logic              in_is_load;
    logic              in_is_store;
    logic [2:0]        in_funct3;
    logic [DATA_W-1:0] in_store_data;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              rf_wen;
    logic [4:0]        rf_rd;
    logic [DATA_W-1:0] rf_wdata;
    logic              commit;
    logic              align_err;

    modport slave (
        input  in_valid, in_rd, in_rf_wen, in_alu_res, in_is_load, in_is_store,
               in_funct3, in_store_data, mem_req_ready, mem_rsp_valid, mem_rdata,
        output in_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
               rf_wen, rf_rd, rf_wdata, commit, align_err
    );

    modport master (
        output in_valid, in_rd, in_rf_wen, in_alu_res, in_is_load, in_is_store,
               in_funct3, in_store_data, mem_req_ready, mem_rsp_valid, mem_rdata,
        input  in_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
               rf_wen, rf_rd, rf_wdata, commit, align_err
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store shift/mask, load extract/extend, access error detection.
// When both class bits are set the access is treated as a store.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        off,
    input  logic [2:0]        funct3,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wmask,
    output logic [DATA_W-1:0] load_data,
    output logic              err
);
    logic [DATA_W-1:0] shifted;
    logic              misaligned;

    always_comb begin
        wdata   = store_data << {off, 3'b000};
        shifted = rdata >> {off, 3'b000};

        wmask = 4'b0000;
        if (is_store) begin
            case (funct3[1:0])
                2'b00:   wmask = 4'b0001 << off;
                2'b01:   wmask = 4'b0011 << off;
                default: wmask = 4'b1111;
            endcase
        end

        case (funct3)
            LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
            LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     load_data = {24'd0, shifted[7:0]};
            LHU:     load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase

        misaligned = (funct3[1:0] == 2'b01 && off[0]) ||
                     (funct3[1:0] == 2'b10 && off != 2'b00);

        err = 1'b0;
        if (is_store)
            err = misaligned || funct3[2] || funct3 == 3'b011;
        else if (is_load)
            err = misaligned || funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111;
    end
endmodule

// File: rtl/lsu_wb.sv
// Load/store + writeback stage: one op in flight, ALU ops retire 1 cycle after accept.
// in_ready only in IDLE; mem request held stable until mem_req_ready.
module lsu_wb
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    lsu_wb_if.slave  bus
);
    state_t state, state_nxt;

    logic [4:0]      rd_q;
    logic            rf_wen_q, is_load_q, is_store_q, err_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] alu_q, sdata_q, ld_q;

    logic            accept, in_load, in_mem;
    logic [1:0]      a_off;
    logic [2:0]      a_f3;
    logic            a_load, a_store, a_err;
    logic [XLEN-1:0] a_sdata, a_wdata, a_ldata;
    logic [3:0]      a_wmask;

    assign accept  = state == IDLE && bus.in_valid;
    assign in_load = bus.in_is_load && !bus.in_is_store;
    assign in_mem  = bus.in_is_load || bus.in_is_store;

    // The aligner looks at the live inputs while IDLE (error check at accept)
    // and at the latched op in every other state.
    always_comb begin
        if (state == IDLE) begin
            a_off   = bus.in_alu_res[1:0];
            a_f3    = bus.in_funct3;
            a_load  = in_load;
            a_store = bus.in_is_store;
            a_sdata = bus.in_store_data;
        end else begin
            a_off   = alu_q[1:0];
            a_f3    = f3_q;
            a_load  = is_load_q;
            a_store = is_store_q;
            a_sdata = sdata_q;
        end
    end

    lsu_align u_align (
        .off        (a_off),
        .funct3     (a_f3),
        .is_load    (a_load),
        .is_store   (a_store),
        .store_data (a_sdata),
        .rdata      (bus.mem_rdata),
        .wdata      (a_wdata),
        .wmask      (a_wmask),
        .load_data  (a_ldata),
        .err        (a_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (!in_mem || a_err) ? WB : REQ;
            REQ:  if (bus.mem_req_ready) state_nxt = WAIT;
            WAIT: if (bus.mem_rsp_valid) state_nxt = WB;
            WB:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        bus.in_ready      = rst_n && state == IDLE;
        bus.mem_req_valid = state == REQ;
        bus.mem_addr      = '0;
        bus.mem_wen       = 1'b0;
        bus.mem_wdata     = '0;
        bus.mem_wmask     = 4'b0000;
        bus.rf_wen        = 1'b0;
        bus.rf_rd         = 5'd0;
        bus.rf_wdata      = '0;
        bus.commit        = 1'b0;
        bus.align_err     = 1'b0;

        if (state == REQ) begin
            bus.mem_addr  = {alu_q[XLEN-1:2], 2'b00};
            bus.mem_wen   = is_store_q;
            bus.mem_wdata = a_wdata;
            bus.mem_wmask = a_wmask;
        end
        if (state == WB) begin
            bus.rf_wen    = rf_wen_q && rd_q != 5'd0 && !err_q && !is_store_q;
            bus.rf_rd     = rd_q;
            bus.rf_wdata  = is_load_q ? ld_q : alu_q;
            bus.commit    = 1'b1;
            bus.align_err = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= 5'd0;
            rf_wen_q   <= 1'b0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            f3_q       <= 3'd0;
            alu_q      <= '0;
            sdata_q    <= '0;
            ld_q       <= '0;
        end else if (accept) begin
            rd_q       <= bus.in_rd;
            rf_wen_q   <= bus.in_rf_wen;
            is_load_q  <= in_load;
            is_store_q <= bus.in_is_store;
            err_q      <= a_err;
            f3_q       <= bus.in_funct3;
            alu_q      <= bus.in_alu_res;
            sdata_q    <= bus.in_store_data;
            ld_q       <= '0;
        end else if (state == WAIT && bus.mem_rsp_valid && is_load_q) begin
            ld_q       <= a_ldata;
        end
    end
endmodule

// File: tb/tb_lsu_wb.sv
// Directed bench for lsu_wb: reset, ALU, loads, stores, errors, stall, reset mid-access, back-to-back.
module tb_lsu_wb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    lsu_wb_if bus ();

    lsu_wb #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [4:0] rd, input logic wen,
                         input logic [31:0] alu, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] sd);
        bus.in_valid      = v;
        bus.in_rd         = rd;
        bus.in_rf_wen     = wen;
        bus.in_alu_res    = alu;
        bus.in_is_load    = ld;
        bus.in_is_store   = st;
        bus.in_funct3     = f3;
        bus.in_store_data = sd;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
        #2;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid got %b want 0", bus.mem_req_valid); end
        n_cmp++; if ({bus.rf_wen, bus.commit, bus.align_err} !== 3'b000) begin n_fail++; $display("FAIL reset_rf_outs got %b want 000", {bus.rf_wen, bus.commit, bus.align_err}); end
        n_cmp++; if (bus.mem_addr !== 32'd0 || bus.rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_buses got %h/%h want 0/0", bus.mem_addr, bus.rf_wdata); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_alu();
        drive(1, 5, 1, 32'h1234, 0, 0, 3'b000, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.rf_wen !== 1'b1) begin n_fail++; $display("FAIL alu_rf_wen got %b want 1", bus.rf_wen); end
        n_cmp++; if (bus.rf_rd !== 5'd5) begin n_fail++; $display("FAIL alu_rf_rd got %0d want 5", bus.rf_rd); end
        n_cmp++; if (bus.rf_wdata !== 32'h1234) begin n_fail++; $display("FAIL alu_rf_wdata got %h want 00001234", bus.rf_wdata); end
        n_cmp++; if (bus.commit !== 1'b1 || bus.align_err !== 1'b0) begin n_fail++; $display("FAIL alu_commit got %b/%b want 1/0", bus.commit, bus.align_err); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL alu_wb_in_ready got %b want 0", bus.in_ready); end
        @(negedge clk);
        n_cmp++; if ({bus.rf_wen, bus.commit, bus.in_ready} !== 3'b001) begin n_fail++; $display("FAIL alu_after_wb got %b want 001", {bus.rf_wen, bus.commit, bus.in_ready}); end
    endtask

    task automatic test_loads();
        logic [31:0] addr [5] = '{32'h8000_0003, 32'h0000_0202, 32'h0000_0202, 32'h0000_0010, 32'h0000_0001};
        logic [2:0]  f3   [5] = '{3'b000, 3'b101, 3'b001, 3'b010, 3'b100};
        logic [31:0] rdat [5] = '{32'h80FF_FFFF, 32'h8001_0000, 32'h8001_0000, 32'hCAFE_F00D, 32'h0000_A500};
        logic [31:0] exp  [5] = '{32'hFFFF_FF80, 32'h0000_8001, 32'hFFFF_8001, 32'hCAFE_F00D, 32'h0000_00A5};
        for (int i = 0; i < 5; i++) begin
            drive(1, 7, 1, addr[i], 1, 0, f3[i], 0);
            @(negedge clk);
            bus.in_valid = 1'b0;
            n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL load%0d_req got vld=%b rf_wen=%b want 1/0", i, bus.mem_req_valid, bus.rf_wen); end
            n_cmp++; if (bus.mem_addr !== {addr[i][31:2], 2'b00}) begin n_fail++; $display("FAIL load%0d_addr got %h want %h", i, bus.mem_addr, {addr[i][31:2], 2'b00}); end
            n_cmp++; if (bus.mem_wen !== 1'b0 || bus.mem_wmask !== 4'b0000) begin n_fail++; $display("FAIL load%0d_wen_mask got %b/%b want 0/0000", i, bus.mem_wen, bus.mem_wmask); end
            @(negedge clk);
            n_cmp++; if (bus.mem_req_valid !== 1'b0 || bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL load%0d_wait got vld=%b rf_wen=%b want 0/0", i, bus.mem_req_valid, bus.rf_wen); end
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rdata     = rdat[i];
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rdata     = 32'hDEAD_DEAD;
            n_cmp++; if (bus.rf_wen !== 1'b1 || bus.commit !== 1'b1) begin n_fail++; $display("FAIL load%0d_wb got rf_wen=%b commit=%b want 1/1", i, bus.rf_wen, bus.commit); end
            n_cmp++; if (bus.rf_wdata !== exp[i]) begin n_fail++; $display("FAIL load%0d_data got %h want %h", i, bus.rf_wdata, exp[i]); end
            n_cmp++; if (bus.rf_rd !== 5'd7) begin n_fail++; $display("FAIL load%0d_rd got %0d want 7", i, bus.rf_rd); end
            @(negedge clk);
        end
    endtask

    task automatic test_stores();
        logic [31:0] addr  [3] = '{32'h0000_0102, 32'h0000_0001, 32'h0000_0010};
        logic [2:0]  f3    [3] = '{3'b001, 3'b000, 3'b010};
        logic        ldbit [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] sd    [3] = '{32'h0000_ABCD, 32'h0000_0055, 32'h1122_3344};
        logic [31:0] ea    [3] = '{32'h0000_0100, 32'h0000_0000, 32'h0000_0010};
        logic [31:0] ewd   [3] = '{32'hABCD_0000, 32'h0000_5500, 32'h1122_3344};
        logic [3:0]  emk   [3] = '{4'b1100, 4'b0010, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            drive(1, 9, 1, addr[i], ldbit[i], 1, f3[i], sd[i]);
            @(negedge clk);
            bus.in_valid = 1'b0;
            n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.mem_wen !== 1'b1) begin n_fail++; $display("FAIL store%0d_req got vld=%b wen=%b want 1/1", i, bus.mem_req_valid, bus.mem_wen); end
            n_cmp++; if (bus.mem_addr !== ea[i]) begin n_fail++; $display("FAIL store%0d_addr got %h want %h", i, bus.mem_addr, ea[i]); end
            n_cmp++; if (bus.mem_wdata !== ewd[i]) begin n_fail++; $display("FAIL store%0d_wdata got %h want %h", i, bus.mem_wdata, ewd[i]); end
            n_cmp++; if (bus.mem_wmask !== emk[i]) begin n_fail++; $display("FAIL store%0d_wmask got %b want %b", i, bus.mem_wmask, emk[i]); end
            @(negedge clk);
            bus.mem_rsp_valid = 1'b1;
            @(negedge clk);
            bus.mem_rsp_valid = 1'b0;
            n_cmp++; if (bus.commit !== 1'b1 || bus.rf_wen !== 1'b0 || bus.align_err !== 1'b0) begin n_fail++; $display("FAIL store%0d_wb got commit=%b rf_wen=%b err=%b want 1/0/0", i, bus.commit, bus.rf_wen, bus.align_err); end
            @(negedge clk);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addr [4] = '{32'h0000_0101, 32'h0000_0000, 32'h0000_0000, 32'h0000_0003};
        logic [2:0]  f3   [4] = '{3'b010, 3'b011, 3'b100, 3'b001};
        logic        ld   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1, 3, 1, addr[i], ld[i], !ld[i], f3[i], 32'hFFFF_FFFF);
            @(negedge clk);
            bus.in_valid = 1'b0;
            n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL err%0d_no_req got %b want 0", i, bus.mem_req_valid); end
            n_cmp++; if ({bus.align_err, bus.commit, bus.rf_wen} !== 3'b110) begin n_fail++; $display("FAIL err%0d_wb got err/commit/rf_wen=%b want 110", i, {bus.align_err, bus.commit, bus.rf_wen}); end
            @(negedge clk);
            n_cmp++; if ({bus.align_err, bus.commit, bus.in_ready} !== 3'b001) begin n_fail++; $display("FAIL err%0d_after got %b want 001", i, {bus.align_err, bus.commit, bus.in_ready}); end
        end
    endtask

    task automatic test_stall();
        bus.mem_req_ready = 1'b0;
        drive(1, 4, 0, 32'h0000_0040, 0, 1, 3'b010, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_cmp++; if (bus.mem_req_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall%0d_hs got vld=%b in_ready=%b want 1/0", c, bus.mem_req_valid, bus.in_ready); end
            n_cmp++; if (bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_wmask !== 4'hF || bus.mem_wen !== 1'b1) begin
                n_fail++; $display("FAIL stall%0d_stable got %h/%h/%b/%b want 00000040/deadbeef/1111/1", c, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.mem_wen); end
            if (c == 3) bus.mem_req_ready = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_wait got %b want 0", bus.mem_req_valid); end
        bus.mem_rsp_valid = 1'b1;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        n_cmp++; if (bus.commit !== 1'b1 || bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL stall_wb got commit=%b rf_wen=%b want 1/0", bus.commit, bus.rf_wen); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        // Reset while in WAIT, then a late response.
        drive(1, 6, 1, 32'h0000_0020, 1, 0, 3'b010, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({bus.mem_req_valid, bus.in_ready, bus.rf_wen, bus.commit} !== 4'b0000) begin n_fail++; $display("FAIL rst_wait_outs got %b want 0000", {bus.mem_req_valid, bus.in_ready, bus.rf_wen, bus.commit}); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'hFFFF_FFFF;
        @(negedge clk);
        n_cmp++; if (bus.rf_wen !== 1'b0 || bus.commit !== 1'b0) begin n_fail++; $display("FAIL rst_late_rsp got rf_wen=%b commit=%b want 0/0", bus.rf_wen, bus.commit); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wait_in_ready got %b want 1", bus.in_ready); end
        bus.mem_rsp_valid = 1'b0;
        // Reset while in REQ drops the request without waiting for a clock.
        bus.mem_req_ready = 1'b0;
        drive(1, 6, 1, 32'h0000_0024, 1, 0, 3'b010, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_req_pre got %b want 1", bus.mem_req_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req_valid !== 1'b0 || bus.mem_addr !== 32'd0) begin n_fail++; $display("FAIL rst_req_drop got vld=%b addr=%h want 0/0", bus.mem_req_valid, bus.mem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_after got in_ready=%b vld=%b want 1/0", bus.in_ready, bus.mem_req_valid); end
    endtask

    task automatic test_back_to_back();
        drive(1, 12, 1, 32'hAAAA_0001, 0, 0, 3'b000, 0);
        @(negedge clk);
        n_cmp++; if (bus.rf_wen !== 1'b1 || bus.rf_wdata !== 32'hAAAA_0001 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_op1 got rf_wen=%b data=%h in_ready=%b want 1/aaaa0001/0", bus.rf_wen, bus.rf_wdata, bus.in_ready); end
        drive(1, 0, 1, 32'hBBBB_0002, 0, 0, 3'b000, 0);
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.commit !== 1'b0) begin n_fail++; $display("FAIL b2b_gap got in_ready=%b commit=%b want 1/0", bus.in_ready, bus.commit); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.commit !== 1'b1 || bus.rf_wen !== 1'b0 || bus.rf_wdata !== 32'hBBBB_0002) begin n_fail++; $display("FAIL b2b_op2_rd0 got commit=%b rf_wen=%b data=%h want 1/0/bbbb0002", bus.commit, bus.rf_wen, bus.rf_wdata); end
        @(negedge clk);
        n_cmp++; if (bus.commit !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_end got commit=%b in_ready=%b want 0/1", bus.commit, bus.in_ready); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_stores();
        test_errors();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
